usb_rx_sr: RTL and testbench
============================

# usb_rx_sr

USB receive shift register: the serial-to-parallel counterpart of the transmit shift register in the USB endpoint path. It takes the NRZI-decoded, bit-unstuffed bit stream LSB-first and assembles 16-bit words. It runs the USB CRC16 over every received bit and reports packet completion with a CRC verdict and a partial-word flag to the USB receive controller.

## Interface

- `WORD_BITS`, 16: word width; fixed at 16 for USB data, and the CRC is always 16-bit.
- `clk` input 1: system clock.
- `n_rst` input 1: synchronous active-low reset.
- `sop` input 1: start-of-packet strobe, one cycle.
- `rx_enable` input 1: receive window open. Bits are accepted only while high.
- `rx_shift` input 1: bit strobe. The bit is valid this cycle.
- `rx_bit` input 1: decoded serial data bit.
- `eop` input 1: end-of-packet strobe, one cycle.
- `rx_data` output 16: last completed word, with the first-received bit in bit 0.
- `rx_valid` output 1: one-cycle pulse; `rx_data` is new.
- `packet_done` output 1: one-cycle pulse at packet end.
- `crc_ok` output 1: CRC verdict, valid from `packet_done` until the next `sop`.
- `partial_err` output 1: the packet ended on a non-word boundary. Valid with `crc_ok`.

## Operation

- **FSM states:** IDLE, RECEIVE, CHECK.
- **IDLE:**
  - `sop` goes to RECEIVE.
  - At that edge: shift register = 0, bit counter = 0, CRC register = 16'hFFFF, `crc_ok` = 0, `partial_err` = 0.
  - `rx_shift` and `eop` are ignored in IDLE.
- **RECEIVE, bit accepted** (`rx_enable && rx_shift`):
  - The shift register shifts right, and `rx_bit` enters bit 15.
  - The 4-bit counter increments and wraps 15 to 0.
  - The CRC updates with the USB polynomial x^16+x^15+x^2+1, LSB-first: `fb = rx_bit ^ crc[15]`, `crc = {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 0)`.
- **Word completion:**
  - On the accepted bit that takes the counter from 15 to 0, `rx_data` loads the completed word. That word is `{rx_bit, shift_reg[15:1]}`.
  - `rx_valid` pulses in the following cycle.
  - Words are delivered back-to-back, with no gap requirement.
- **eop in RECEIVE:**
  - Go to CHECK.
  - If `rx_shift` arrives in the same cycle, that bit is accepted first, and may complete a word.
- **CHECK:** lasts one cycle, then returns to IDLE.
  - `packet_done` = 1.
  - `crc_ok` = 1 iff the CRC register is 16'h800D. This is the USB residual after payload plus transmitted CRC.
  - `partial_err` = 1 iff the counter is not 0.
  - `crc_ok` and `partial_err` are held until the next `sop`.
- **sop in RECEIVE or CHECK:** restart the packet.
  - Reinitialise as from IDLE and discard the partial word; no `rx_valid` is produced for it.
  - In CHECK, `packet_done` still pulses that cycle.
- **rx_enable low in RECEIVE:** strobes are ignored and all state holds. This is not an abort.
- **CRC bits:** the trailing CRC bits are shifted into words like payload. For a whole-word payload, the last delivered word is the CRC field itself; the controller discards it.

## Timing

- **Reset values:** `rx_data` = 16'h0000; `rx_valid`, `packet_done`, `crc_ok`, `partial_err` = 0; FSM = IDLE; CRC = 16'hFFFF.
- **Reset priority:** reset is synchronous and wins over all inputs. Reset mid-packet drops everything, and no `packet_done` is produced.
- **Latency:**
  - `rx_valid` is high in the cycle after the clock edge that sampled the 16th bit.
  - `rx_data` is stable from that cycle until the next word completes.
  - `packet_done` is high in the cycle after the edge that sampled `eop`.
- **Outputs:** all are registered, with no combinational input-to-output paths.
- **Throughput:** up to one bit per clock. `rx_shift` may be high continuously.

## Test plan

- **Word assembly:** after `sop`, feed 16'hA5C3 LSB-first as 16 consecutive strobes -> one `rx_valid` pulse with `rx_data` = 16'hA5C3, then exactly one cycle later `rx_valid` = 0.
- **Good CRC and stalls:** send payload words 16'h0100, 16'h0302, then their CRC16 from the bench reference model (complemented, LSB-first), then `eop`.
  - Required response: three `rx_valid` pulses, then `packet_done` with `crc_ok` = 1 and `partial_err` = 0.
  - Repeat with random `rx_enable`/`rx_shift` gaps; the result must be identical.
- **Bad CRC:** the same packet with payload bit 5 flipped -> `crc_ok` = 0, `partial_err` = 0, and the `rx_data` values reflect the flipped bit.
- **Partial word:** 20 bits then `eop` -> one `rx_valid`, then `packet_done` with `partial_err` = 1.
- **Simultaneous events:**
  - The 16th bit and `eop` in the same cycle -> `rx_valid` and `packet_done` both pulse in the next cycle, with `partial_err` = 0.
  - `sop` after 7 bits -> no `rx_valid`, and the counter restarts from 0.
- **Reset:** assert `n_rst` low for one cycle after 9 bits -> all outputs 0 next cycle. A following packet of 16'hFFFF decodes correctly, and `eop` without `sop` produces no `packet_done`.

Source files
------------

// File: rtl/usb_rx_sr_if.sv
// Bundle between the USB receive controller and the receive shift register.
// The controller drives bit strobes and packet framing; the shift register returns words and the packet verdict.
interface usb_rx_sr_if #(
  parameter int WORD_BITS = 16
);
  logic                 sop;
  logic                 rx_enable;
  logic                 rx_shift;
  logic                 rx_bit;
  logic                 eop;
  logic [WORD_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 packet_done;
  logic                 crc_ok;
  logic                 partial_err;

  modport master (
    output sop, rx_enable, rx_shift, rx_bit, eop,
    input  rx_data, rx_valid, packet_done, crc_ok, partial_err
  );

  modport slave (
    input  sop, rx_enable, rx_shift, rx_bit, eop,
    output rx_data, rx_valid, packet_done, crc_ok, partial_err
  );
endinterface

// File: rtl/usb_rx_sr.sv
// USB receive shift register: assembles LSB-first bits into words and checks the
// packet CRC16 residual at end of packet.
module usb_rx_sr #(
  parameter int WORD_BITS = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  usb_rx_sr_if.slave  bus
);
  localparam int CW = $clog2(WORD_BITS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  localparam logic [15:0]   CRC_INIT     = 16'hFFFF;
  localparam logic [15:0]   CRC_RESIDUAL = 16'h800D;
  localparam logic [15:0]   CRC_POLY     = 16'h8005;
  localparam logic [CW-1:0] CNT_LAST     = CW'(WORD_BITS - 1);

  // One LSB-first CRC16 step in the shift-left register form.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  logic [1:0]           state_r;
  logic [WORD_BITS-1:0] shift_r;
  logic [CW-1:0]        cnt_r;
  logic [15:0]          crc_r;
  logic [WORD_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 packet_done_r;
  logic                 crc_ok_r;
  logic                 partial_err_r;

  logic [1:0]           state_next_s;
  logic                 accept_s;
  logic                 word_done_s;
  logic                 restart_s;
  logic                 enter_check_s;
  logic [WORD_BITS-1:0] shift_next_s;
  logic [CW-1:0]        cnt_next_s;
  logic [15:0]          crc_next_s;

  // Bit acceptance and the datapath values after a possible accepted bit.
  always_comb begin
    accept_s      = (state_r == ST_RECEIVE) && bus.rx_enable && bus.rx_shift;
    word_done_s   = accept_s && (cnt_r == CNT_LAST);
    shift_next_s  = shift_r;
    cnt_next_s    = cnt_r;
    crc_next_s    = crc_r;
    if (accept_s) begin
      shift_next_s = {bus.rx_bit, shift_r[WORD_BITS-1:1]};
      cnt_next_s   = cnt_r + CW'(1);
      crc_next_s   = crc16_step(crc_r, bus.rx_bit);
    end else begin
      shift_next_s = shift_r;
    end
  end

  // Packet framing FSM; sop restarts from any legal state, eop is a strobe gated by rx_enable.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.sop) state_next_s = ST_RECEIVE;
        else         state_next_s = ST_IDLE;
      end
      ST_RECEIVE: begin
        if (bus.sop)                        state_next_s = ST_RECEIVE;
        else if (bus.rx_enable && bus.eop)  state_next_s = ST_CHECK;
        else                                state_next_s = ST_RECEIVE;
      end
      ST_CHECK: begin
        if (bus.sop) state_next_s = ST_RECEIVE;
        else         state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
    restart_s     = bus.sop && (state_next_s == ST_RECEIVE);
    enter_check_s = (state_r == ST_RECEIVE) && (state_next_s == ST_CHECK);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r       <= ST_IDLE;
      shift_r       <= '0;
      cnt_r         <= '0;
      crc_r         <= CRC_INIT;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      packet_done_r <= 1'b0;
      crc_ok_r      <= 1'b0;
      partial_err_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      rx_valid_r    <= 1'b0;
      packet_done_r <= 1'b0;
      if (restart_s) begin
        // A restart discards any partial word without delivering it.
        shift_r       <= '0;
        cnt_r         <= '0;
        crc_r         <= CRC_INIT;
        crc_ok_r      <= 1'b0;
        partial_err_r <= 1'b0;
      end else begin
        shift_r <= shift_next_s;
        cnt_r   <= cnt_next_s;
        crc_r   <= crc_next_s;
        if (word_done_s) begin
          rx_data_r  <= shift_next_s;
          rx_valid_r <= 1'b1;
        end
        if (enter_check_s) begin
          packet_done_r <= 1'b1;
          crc_ok_r      <= (crc_next_s == CRC_RESIDUAL);
          partial_err_r <= (cnt_next_s != '0);
        end
      end
    end
  end

  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.packet_done = packet_done_r;
  assign bus.crc_ok      = crc_ok_r;
  assign bus.partial_err = partial_err_r;
endmodule

// File: tb/tb_usb_rx_sr.sv
// Directed bench for usb_rx_sr: word assembly, CRC verdicts, partial words,
// simultaneous events and reset behaviour.
module tb_usb_rx_sr;
  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  usb_rx_sr_if #(.WORD_BITS(16)) bus ();

  usb_rx_sr #(.WORD_BITS(16)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] words[$];
  logic [15:0] crc_field;
  logic [15:0] crc_acc;
  logic [15:0] v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Capture every delivered word mid-cycle.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) words.push_back(bus.rx_data);
  end

  function automatic logic [31:0] word_at(input int i);
    if (i < words.size()) return {16'h0000, words[i]};
    else return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 16; i++) begin
      fb = w[i] ^ r[15];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h8005;
    end
    return r;
  endfunction

  function automatic logic [15:0] bitrev_inv(input logic [15:0] c);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = ~c[15 - i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    int n;
    if (gaps) begin
      n = int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        bus.rx_enable = 1'($urandom_range(0, 1));
        bus.rx_shift  = ~bus.rx_enable;
        bus.rx_bit    = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus.rx_enable = 1'b1;
    bus.rx_shift  = 1'b1;
    bus.rx_bit    = b;
    tick();
    bus.rx_shift  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    for (int i = 0; i < 16; i++) send_bit(w[i], gaps);
  endtask

  task automatic start_packet();
    words.delete();
    bus.sop = 1'b1;
    tick();
    bus.sop = 1'b0;
  endtask

  task automatic end_packet();
    bus.eop = 1'b1;
    tick();
    bus.eop = 1'b0;
  endtask

  task automatic crc_packet(input string tag, input logic [15:0] w0, input bit gaps,
                            input logic exp_ok);
    start_packet();
    send_word(w0, gaps);
    send_word(16'h0302, gaps);
    send_word(crc_field, gaps);
    end_packet();
    check({tag, "_done"},    32'(bus.packet_done), 32'd1);
    check({tag, "_crc_ok"},  32'(bus.crc_ok), 32'(exp_ok));
    check({tag, "_partial"}, 32'(bus.partial_err), 32'd0);
    check({tag, "_nwords"},  32'(words.size()), 32'd3);
    check({tag, "_w0"},      word_at(0), {16'h0000, w0});
    check({tag, "_w1"},      word_at(1), 32'h0000_0302);
    check({tag, "_w2"},      word_at(2), {16'h0000, crc_field});
    tick();
    check({tag, "_done_end"}, 32'(bus.packet_done), 32'd0);
    check({tag, "_crc_held"}, 32'(bus.crc_ok), 32'(exp_ok));
  endtask

  initial begin
    bus.sop       = 1'b0;
    bus.rx_enable = 1'b0;
    bus.rx_shift  = 1'b0;
    bus.rx_bit    = 1'b0;
    bus.eop       = 1'b0;
    n_rst         = 1'b0;
    tick();
    tick();
    check("rst_data",    32'(bus.rx_data), 32'd0);
    check("rst_valid",   32'(bus.rx_valid), 32'd0);
    check("rst_done",    32'(bus.packet_done), 32'd0);
    check("rst_crc_ok",  32'(bus.crc_ok), 32'd0);
    check("rst_partial", 32'(bus.partial_err), 32'd0);
    n_rst = 1'b1;
    tick();

    // Word assembly with exact rx_valid pulse width.
    start_packet();
    send_word(16'hA5C3, 1'b0);
    check("asm_valid", 32'(bus.rx_valid), 32'd1);
    check("asm_data",  32'(bus.rx_data), 32'h0000_A5C3);
    tick();
    check("asm_valid_low", 32'(bus.rx_valid), 32'd0);
    check("asm_data_hold", 32'(bus.rx_data), 32'h0000_A5C3);
    end_packet();
    check("asm_done",    32'(bus.packet_done), 32'd1);
    check("asm_partial", 32'(bus.partial_err), 32'd0);
    tick();

    // Good CRC, the same with gaps, then a corrupted payload bit 5.
    crc_acc   = crc_upd(16'hFFFF, 16'h0100);
    crc_acc   = crc_upd(crc_acc, 16'h0302);
    crc_field = bitrev_inv(crc_acc);
    crc_packet("good", 16'h0100, 1'b0, 1'b1);
    crc_packet("gaps", 16'h0100, 1'b1, 1'b1);
    crc_packet("bad",  16'h0120, 1'b0, 1'b0);

    // Partial word: 20 bits.
    start_packet();
    send_word(16'h1234, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    end_packet();
    check("part_done",    32'(bus.packet_done), 32'd1);
    check("part_partial", 32'(bus.partial_err), 32'd1);
    check("part_nwords",  32'(words.size()), 32'd1);
    check("part_w0",      word_at(0), 32'h0000_1234);
    tick();

    // 16th bit and eop in the same cycle.
    start_packet();
    v = 16'hBEEF;
    for (int i = 0; i < 15; i++) send_bit(v[i], 1'b0);
    bus.eop = 1'b1;
    send_bit(v[15], 1'b0);
    bus.eop = 1'b0;
    check("sim_valid",   32'(bus.rx_valid), 32'd1);
    check("sim_done",    32'(bus.packet_done), 32'd1);
    check("sim_data",    32'(bus.rx_data), 32'h0000_BEEF);
    check("sim_partial", 32'(bus.partial_err), 32'd0);
    tick();

    // sop after 7 bits restarts the word.
    start_packet();
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    bus.sop = 1'b1;
    tick();
    bus.sop = 1'b0;
    check("restart_nowords", 32'(words.size()), 32'd0);
    send_word(16'h5A5A, 1'b0);
    tick();
    check("restart_nwords", 32'(words.size()), 32'd1);
    check("restart_w0",     word_at(0), 32'h0000_5A5A);
    end_packet();
    tick();

    // Reset mid-packet after 9 bits.
    start_packet();
    for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b0);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check("mrst_data",    32'(bus.rx_data), 32'd0);
    check("mrst_valid",   32'(bus.rx_valid), 32'd0);
    check("mrst_done",    32'(bus.packet_done), 32'd0);
    check("mrst_crc_ok",  32'(bus.crc_ok), 32'd0);
    check("mrst_partial", 32'(bus.partial_err), 32'd0);
    end_packet();
    check("mrst_eop_nodone", 32'(bus.packet_done), 32'd0);
    start_packet();
    send_word(16'hFFFF, 1'b0);
    end_packet();
    check("post_done",    32'(bus.packet_done), 32'd1);
    check("post_partial", 32'(bus.partial_err), 32'd0);
    check("post_nwords",  32'(words.size()), 32'd1);
    check("post_w0",      word_at(0), 32'h0000_FFFF);
    tick();
    end_packet();
    check("idle_eop_nodone", 32'(bus.packet_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
